pixie_dma_fetch: RTL and testbench

//  Upstream feeder for the Studio II Pixie video stage. Captures CDP1802 DMA-out bytes
//  (SC=2'b10) during display DMA windows and tracks the display-RAM address, assembling

---
 rtl/pixie_dma_fetch.sv | 130 +++++++++++++
 tb/tb_pixie_dma_fetch.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/pixie_dma_fetch.sv
// pixie_dma_fetch: captures CDP1802 display-DMA bytes into ping-pong 8-byte line banks for the Pixie video stage.
// Define PIXIE_DMA_CHECKSUM_EN to build the per-frame modulo-256 byte checksum.
module pixie_dma_fetch #(
   parameter int          BYTES_PER_LINE  = 8,
   parameter int          LINES_PER_FRAME = 32,
   parameter logic [15:0] START_ADDR      = 16'h0900
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        clk_enable,
   input  logic [1:0]  SC,
   input  logic        dmao_n,
   input  logic        frame_start,
   input  logic [7:0]  data_in,
   output logic [15:0] mem_addr,
   output logic        line_valid,
   input  logic        line_ready,
   output logic [63:0] line_data,
   output logic [4:0]  line_index,
   output logic        frame_done,
   output logic        overrun,
   output logic [7:0]  frame_checksum
);
   typedef enum logic [1:0] {IDLE, FILL, WAIT_BANK} state_t;
   state_t      state;
   logic [63:0] bank_data [2];
   logic [4:0]  bank_row [2];
   logic [1:0]  bank_full;
   logic        fill_bank, rd_ptr;
   logic [2:0]  cnt;
   logic [4:0]  row;
   logic [7:0]  addr_off;
   logic        cap, take, wr, last_byte, last_row, frame_end;
   assign cap        = clk_enable && SC == 2'b10 && !dmao_n;
   assign take       = line_valid && line_ready;
   assign wr         = state == FILL && cap && !bank_full[fill_bank];
   assign last_byte  = cnt == 3'(BYTES_PER_LINE - 1);
   assign last_row   = row == 5'(LINES_PER_FRAME - 1);
   assign frame_end  = wr && last_byte && last_row;
   assign mem_addr   = START_ADDR + {8'h00, addr_off};
   // The oldest full bank is always the one rd_ptr names, since banks fill alternately.
   assign line_valid = bank_full[rd_ptr];
   assign line_data  = bank_data[rd_ptr];
   assign line_index = bank_row[rd_ptr];
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         bank_data[0] <= '0;
         bank_data[1] <= '0;
         bank_row[0]  <= '0;
         bank_row[1]  <= '0;
         bank_full    <= '0;
         fill_bank    <= 1'b0;
         rd_ptr       <= 1'b0;
         cnt          <= '0;
         row          <= '0;
         addr_off     <= '0;
         frame_done   <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (take) begin
            bank_full[rd_ptr] <= 1'b0;
            rd_ptr            <= ~rd_ptr;
         end
         if (frame_start) begin
            state    <= FILL;
            cnt      <= '0;
            row      <= '0;
            addr_off <= '0;
            if (state != IDLE) begin
               bank_full <= '0;
               fill_bank <= 1'b0;
               rd_ptr    <= 1'b0;
            end
         end else begin
            if (cap && state != IDLE) addr_off <= addr_off + 8'd1;
            case (state)
               FILL: begin
                  // A bank still held from the previous frame cannot take bytes yet.
                  if (cap && bank_full[fill_bank]) overrun <= 1'b1;
                  if (wr) begin
                     bank_data[fill_bank][{~cnt, 3'b000} +: 8] <= data_in;
                     cnt <= cnt + 3'd1;
                     if (last_byte) begin
                        bank_full[fill_bank] <= 1'b1;
                        bank_row[fill_bank]  <= row;
                        if (last_row) begin
                           frame_done <= 1'b1;
                           state      <= IDLE;
                           fill_bank  <= ~fill_bank;
                        end else if (!bank_full[~fill_bank]) begin
                           fill_bank <= ~fill_bank;
                           row       <= row + 5'd1;
                        end else begin
                           state <= WAIT_BANK;
                        end
                     end
                  end
               end
               WAIT_BANK: begin
                  if (cap) overrun <= 1'b1;
                  if (!bank_full[~fill_bank]) begin
                     fill_bank <= ~fill_bank;
                     row       <= row + 5'd1;
                     state     <= FILL;
                  end
               end
               default: ;
            endcase
         end
      end
   end
`ifdef PIXIE_DMA_CHECKSUM_EN
   logic [7:0] sum;
   always_ff @(posedge clk) begin
      if (reset) begin
         sum            <= '0;
         frame_checksum <= '0;
      end else if (frame_start) begin
         sum <= '0;
      end else if (wr) begin
         sum <= sum + data_in;
         if (frame_end) frame_checksum <= sum + data_in;
      end
   end
`else
   assign frame_checksum = 8'h00;
`endif
endmodule

// File: tb/tb_pixie_dma_fetch.sv
// tb_pixie_dma_fetch: queue-based reference model with per-cycle output compare plus directed scenarios.
module tb_pixie_dma_fetch;
   logic        clk = 1'b0, reset = 1'b1, clk_enable = 1'b0, dmao_n = 1'b1, frame_start = 1'b0, line_ready = 1'b0;
   logic [1:0]  SC = 2'b00;
   logic [7:0]  data_in = 8'h00;
   logic [15:0] mem_addr;
   logic        line_valid, frame_done, overrun;
   logic [63:0] line_data;
   logic [4:0]  line_index;
   logic [7:0]  frame_checksum;
   int n_cmp = 0, n_bad = 0;
   always #5 clk = ~clk;
   pixie_dma_fetch dut (
      .clk(clk), .reset(reset), .clk_enable(clk_enable), .SC(SC), .dmao_n(dmao_n),
      .frame_start(frame_start), .data_in(data_in), .mem_addr(mem_addr),
      .line_valid(line_valid), .line_ready(line_ready), .line_data(line_data),
      .line_index(line_index), .frame_done(frame_done), .overrun(overrun),
      .frame_checksum(frame_checksum)
   );
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   // Reference model: lines waiting for the video stage, and whether the filler has a bank.
   typedef struct {logic [4:0] idx; logic [63:0] data;} line_t;
   line_t       q[$];
   bit          m_live = 0, m_active, m_blocked, m_fd, m_ovr, cap, wb;
   int          m_nbytes, m_lines, qn;
   logic [63:0] m_part;
   logic [7:0]  m_off, m_sum, m_ck;
   always @(posedge clk) begin
      cap  = clk_enable && SC == 2'b10 && !dmao_n;
      qn   = q.size();
      m_fd = 0;
      if (reset) begin
         q.delete();
         m_live = 1; m_active = 0; m_blocked = 0; m_ovr = 0;
         m_off = 0; m_nbytes = 0; m_lines = 0; m_part = '0; m_sum = 0; m_ck = 0;
      end else if (frame_start) begin
         if (m_active) q.delete();
         m_active = 1; m_blocked = 0; m_off = 0; m_nbytes = 0; m_lines = 0; m_sum = 0;
      end else begin
         if (qn > 0 && line_ready) void'(q.pop_front());
         wb = m_blocked;
         if (wb && qn < 2) m_blocked = 0;
         if (m_active && cap) begin
            m_off++;
            if (wb) m_ovr = 1;
            else begin
               m_part[8*(7-m_nbytes) +: 8] = data_in;
               m_nbytes++;
               m_sum += data_in;
               if (m_nbytes == 8) begin
                  q.push_back('{5'(m_lines), m_part});
                  m_nbytes = 0;
                  if (m_lines == 31) begin
                     m_fd = 1;
                     m_active = 0;
`ifdef PIXIE_DMA_CHECKSUM_EN
                     m_ck = m_sum;
`endif
                  end else begin
                     m_lines++;
                     m_blocked = qn != 0;
                  end
               end
            end
         end
      end
   end
   logic [63:0] row0;
   int fd_cnt = 0, hs_cnt = 0, last_idx = -1;
   always @(negedge clk) begin
      if (m_live) begin
         chk("mem_addr", mem_addr, 16'h0900 + {8'h00, m_off});
         chk("line_valid", line_valid, q.size() > 0);
         if (q.size() > 0) begin
            chk("line_data", line_data, q[0].data);
            chk("line_index", line_index, q[0].idx);
         end
         chk("frame_done", frame_done, m_fd);
         chk("overrun", overrun, m_ovr);
         chk("frame_checksum", frame_checksum, m_ck);
      end
      if (!reset) begin
         if (frame_done) fd_cnt++;
         if (line_valid && line_ready) begin
            hs_cnt++;
            last_idx = line_index;
            if (line_index == 0) row0 = line_data;
         end
      end
   end
   task automatic bus(input bit ce, input logic [1:0] sc, input bit dn, input logic [7:0] d, input bit fs);
      @(posedge clk);
      #1;
      clk_enable = ce; SC = sc; dmao_n = dn; data_in = d; frame_start = fs;
   endtask
   task automatic cap_b(input logic [7:0] d);
      bus(1, 2'b10, 0, d, 0);
   endtask
   task automatic idle();
      bus(0, 2'b00, 1, 8'h00, 0);
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end
   initial begin
      repeat (3) idle();
      reset = 0;
      // Full frame with the video stage always ready; bus noise must not capture.
      line_ready = 1; fd_cnt = 0; hs_cnt = 0;
      bus(0, 2'b00, 1, 8'h00, 1);
      for (int k = 0; k < 256; k++) begin
         cap_b(8'(k));
         if (k % 37 == 5) begin
            bus(0, 2'b10, 0, 8'hFF, 0);
            bus(1, 2'b01, 0, 8'hEE, 0);
            bus(1, 2'b10, 1, 8'hDD, 0);
         end
      end
      repeat (3) idle();
      chk("t2_frame_done_count", fd_cnt, 1);
      chk("t2_handshakes", hs_cnt, 32);
      chk("t2_last_index", last_idx, 31);
      chk("t2_row0", row0, 64'h0001020304050607);
      chk("t2_addr_wrap", mem_addr, 16'h0900);
`ifdef PIXIE_DMA_CHECKSUM_EN
      chk("t2_checksum", frame_checksum, 8'h80);
`else
      chk("t2_checksum", frame_checksum, 8'h00);
`endif
      // Backpressure: both banks fill, the 17th byte is dropped.
      line_ready = 0;
      bus(0, 2'b00, 1, 8'h00, 1);
      for (int i = 0; i < 17; i++) cap_b(8'hA0 + 8'(i));
      idle();
      chk("t3_overrun", overrun, 1);
      chk("t3_addr", mem_addr, 16'h0911);
      chk("t3_valid", line_valid, 1);
      chk("t3_index", line_index, 0);
      hs_cnt = 0;
      line_ready = 1;
      repeat (3) idle();
      for (int i = 0; i < 8; i++) cap_b(8'hC0 + 8'(i));
      repeat (2) idle();
      chk("t3_handshakes", hs_cnt, 3);
      chk("t3_last_index", last_idx, 2);
      // Abort after 12 caps, with a cap in the same clock as frame_start.
      line_ready = 0;
      bus(0, 2'b00, 1, 8'h00, 1);
      for (int i = 0; i < 12; i++) cap_b(8'h10 + 8'(i));
      chk("t4_valid_before", line_valid, 1);
      bus(1, 2'b10, 0, 8'h55, 1);
      idle();
      chk("t4_valid_flushed", line_valid, 0);
      chk("t4_addr", mem_addr, 16'h0900);
      for (int i = 0; i < 8; i++) cap_b(8'h30 + 8'(i));
      idle();
      chk("t4_valid", line_valid, 1);
      chk("t4_index", line_index, 0);
      chk("t4_data", line_data, 64'h3031323334353637);
      chk("t4_overrun_sticky", overrun, 1);
      line_ready = 1;
      repeat (2) idle();
      // Row1 completes in the same clock that row0 is accepted.
      line_ready = 0;
      bus(0, 2'b00, 1, 8'h00, 1);
      for (int i = 0; i < 8; i++) cap_b(8'h40 + 8'(i));
      for (int i = 0; i < 7; i++) cap_b(8'h50 + 8'(i));
      cap_b(8'h57);
      line_ready = 1;
      idle();
      line_ready = 0;
      chk("t5_valid", line_valid, 1);
      chk("t5_index", line_index, 1);
      chk("t5_data", line_data, 64'h5051525354555657);
      idle();
      line_ready = 1;
      repeat (2) idle();
      for (int i = 0; i < 8; i++) cap_b(8'h60 + 8'(i));
      repeat (2) idle();
      // Frame of all 8'h01: the sum wraps to zero.
      fd_cnt = 0;
      bus(0, 2'b00, 1, 8'h00, 1);
      for (int i = 0; i < 256; i++) cap_b(8'h01);
      repeat (3) idle();
      chk("t6_frame_done_count", fd_cnt, 1);
      chk("t6_checksum", frame_checksum, 8'h00);
      // Reset held mid-frame.
      line_ready = 0;
      bus(0, 2'b00, 1, 8'h00, 1);
      for (int i = 0; i < 20; i++) cap_b(8'h70 + 8'(i));
      reset = 1;
      repeat (3) idle();
      chk("t1_addr", mem_addr, 16'h0900);
      chk("t1_valid", line_valid, 0);
      chk("t1_data", line_data, 64'h0);
      chk("t1_index", line_index, 0);
      chk("t1_frame_done", frame_done, 0);
      chk("t1_overrun", overrun, 0);
      chk("t1_checksum", frame_checksum, 8'h00);
      reset = 0;
      cap_b(8'h99);
      cap_b(8'h9A);
      idle();
      chk("t1_idle_ignores_cap", mem_addr, 16'h0900);
      chk("t1_idle_no_line", line_valid, 0);
      idle();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
